// File: rtl/gout_uart_tx_pkg.sv
// Shared definitions for the gout UART trace transmitter: TX state
// encodings, ASCII base codes and the default baud divisor.
package gout_uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  // 100 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/gout_uart_tx_fifo.sv
// Small synchronous show-ahead FIFO for core output taps. dout always
// presents the oldest entry so a consumer can latch it in the pop cycle.
// A push into a full FIFO is accepted only when a pop frees a slot in
// the same cycle.
module gout_fifo #(
  parameter int DATA_W  = 4,
  parameter int FIFO_AW = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: data only, never reset
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gout_uart_tx.sv
// Turns every change of the core's 4-bit general output into one ASCII
// hex character on an 8N1 UART line. Changes are queued in a small FIFO
// so short bursts survive while a frame is in flight; a change that finds
// the FIFO full is dropped and flagged on the sticky overflow output.
module gout_uart_tx
  import gout_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] gout,
  output logic       txd,
  output logic       busy,
  output logic       overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic [3:0]        prev_gout;

  logic              push;
  logic              pop;
  logic [3:0]        fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              bit_done;

  // Nibble to ASCII hex digit, upper-case letters
  function automatic logic [7:0] encode_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_0 + {4'h0, n};
    end else begin
      return ASCII_A + {4'h0, n} - 8'd10;
    end
  endfunction

  assign push     = ~reset & (gout != prev_gout);
  assign pop      = (state == TX_IDLE) & ~fifo_empty;
  assign bit_done = (baud_cnt == '0);
  assign busy     = (state != TX_IDLE) | ~fifo_empty;

  gout_fifo #(
    .DATA_W  (4),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .din   (gout),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Change detector; tracks gout through reset so release is silent
  always_ff @(posedge CLK) begin
    if (reset || (gout != prev_gout)) begin
      prev_gout <= gout;
    end
  end

  // Sticky flag for a change lost to a full FIFO with no pop to make room
  always_ff @(posedge CLK) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Frame shift register: load on pop, shift right after each data bit
  always_ff @(posedge CLK) begin
    if (pop) begin
      shift_reg <= encode_hex(fifo_dout);
    end else if ((state == TX_DATA) && bit_done) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // TX state machine with baud counter; txd is registered here
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= TX_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            baud_cnt <= BAUD_LOAD;
            txd      <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (!bit_done) begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end else begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= 3'd0;
            txd      <= shift_reg[0];
            state    <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (!bit_done) begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end else begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              // shift_reg moves right this same edge, so bit 1 is next
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift_reg[1];
            end
          end
        end
        TX_STOP: begin
          if (!bit_done) begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end else begin
            state <= TX_IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gout_uart_tx.sv
// Bench for gout_uart_tx with CLKS_PER_BIT=4. Stimulus pushes expected
// characters into a queue; an independent UART receiver decodes txd and
// compares each received byte against the queue head.
module tb_gout_uart_tx;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] gout = 4'h0;
  logic       txd;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int frames = 0;
  int last_start = 0;
  int prev_start = 0;
  logic [7:0] exp_q [$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  gout_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (2)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .gout     (gout),
    .txd      (txd),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      step();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // UART receiver: samples mid-bit on the falling clock edge
  initial begin
    logic       active;
    int         cnt;
    int         j;
    logic [7:0] rx;
    logic       prev_txd;
    logic [7:0] expv;
    active = 1'b0;
    cnt = 0;
    rx = 8'h00;
    prev_txd = 1'b1;
    forever begin
      @(negedge CLK);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (prev_txd === 1'b1 && txd === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          prev_start = last_start;
          last_start = cycle;
        end
      end else begin
        cnt++;
      end
      if (active && (cnt % CPB) == 2) begin
        j = cnt / CPB;
        if (j == 0) begin
          check("rx_start_bit", {31'd0, txd}, 32'd0);
        end else if (j <= 8) begin
          rx[j-1] = txd;
        end else begin
          check("rx_stop_bit", {31'd0, txd}, 32'd1);
          frames++;
          active = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected_frame actual=%0h required=none", rx);
          end else begin
            expv = exp_q.pop_front();
            check("rx_frame", {24'd0, rx}, {24'd0, expv});
          end
        end
      end
      prev_txd = txd;
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;

    // 1: reset state, then a quiet line with gout held
    reset = 1'b1;
    gout  = 4'h3;
    step();
    step();
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("t1_txd_idle", {31'd0, txd}, 32'd1);
      check("t1_busy_idle", {31'd0, busy}, 32'd0);
      check("t1_ovf_idle", {31'd0, overflow}, 32'd0);
    end
    check("t1_no_frames", frames, 0);

    // 2: 0 -> 5, '5' = 8'h35, exact timing of start and busy
    reset = 1'b1;
    gout  = 4'h0;
    step();
    step();
    reset = 1'b0;
    step();
    gout = 4'h5;
    exp_q.push_back(8'h35);
    step();
    check("t2_txd_push_edge", {31'd0, txd}, 32'd1);
    check("t2_busy_push_edge", {31'd0, busy}, 32'd1);
    step();
    check("t2_txd_start", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 39; i++) step();
    check("t2_busy_in_frame", {31'd0, busy}, 32'd1);
    step();
    check("t2_busy_done", {31'd0, busy}, 32'd0);
    check("t2_txd_done", {31'd0, txd}, 32'd1);
    check("t2_frames", frames, 1);

    // 3: 'A' then 'F' queued back to back, one idle cycle between frames
    gout = 4'hA;
    exp_q.push_back(8'h41);
    step();
    gout = 4'hF;
    exp_q.push_back(8'h46);
    step();
    wait_idle(200, "t3_idle_timeout");
    check("t3_frame_gap", last_start - prev_start, 10 * CPB + 1);

    // 4: six changes on consecutive cycles; sixth dropped
    for (int i = 1; i <= 6; i++) begin
      gout = 4'(i);
      if (i <= 5) exp_q.push_back(8'h30 + 8'(i));
      step();
      if (i == 5) check("t4_ovf_before", {31'd0, overflow}, 32'd0);
      if (i == 6) check("t4_ovf_set", {31'd0, overflow}, 32'd1);
    end
    wait_idle(400, "t4_idle_timeout");
    check("t4_ovf_held", {31'd0, overflow}, 32'd1);

    // 5: one-cycle glitch 3 -> 7 -> 3 gives two frames
    gout = 4'h3;
    exp_q.push_back(8'h33);
    step();
    wait_idle(200, "t5a_idle_timeout");
    gout = 4'h7;
    exp_q.push_back(8'h37);
    step();
    gout = 4'h3;
    exp_q.push_back(8'h33);
    step();
    wait_idle(200, "t5b_idle_timeout");
    check("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    check("t5_queue_drained", exp_q.size(), 0);

    // 6: reset during bit 4 of 'C' with 'D','E' queued
    gout = 4'hC;
    step();
    gout = 4'hD;
    step();
    gout = 4'hE;
    step();
    for (int i = 0; i < 20; i++) step();
    check("t6_bit4_low", {31'd0, txd}, 32'd0);
    snap = frames;
    reset = 1'b1;
    gout  = 4'hB;
    step();
    check("t6_rst_txd", {31'd0, txd}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("t6_txd_quiet", {31'd0, txd}, 32'd1);
      check("t6_busy_quiet", {31'd0, busy}, 32'd0);
    end
    check("t6_no_frames", frames, snap);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
